// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets and STATUS bit positions.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic [31:0] TXDATA_OFF = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFF = 32'h0000_0004;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_SHIFTING  = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_PARITY    = 4;
    localparam int STAT_COUNT_LSB = 8;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with naturally wrapping pointers and a one-bit-wider count.
// Pushes are dropped when full, even if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // NOTE: non-blocking assignments for all state, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core store path.
// Define MMIO_UART_PARITY_EN to insert an even-parity bit between data and stop.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int          CLK_DIV    = 868,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy
);

    localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
    localparam int          BW          = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLK_DIV - 1);
    localparam logic [31:0] TXDATA_ADDR = BASE_ADDR + TXDATA_OFF;
    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + STATUS_OFF;

    logic          sel_txdata;
    logic          sel_status;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_d;
    logic          frame_end;
    logic          busy_d;
    logic [31:0]   status;
    logic          unused_bits;

    uart_state_e   state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          busy_q;
    logic          overflow_q;
`ifdef MMIO_UART_PARITY_EN
    logic          parity_q;
`endif

    assign hit         = (address[31:3] == BASE_ADDR[31:3]);
    assign sel_txdata  = (address[31:2] == TXDATA_ADDR[31:2]);
    assign sel_status  = (address[31:2] == STATUS_ADDR[31:2]);
    assign push        = we && sel_txdata;
    assign pop         = (state_q == ST_IDLE) && !fifo_empty;
    assign unused_bits = ^{func3, address[1:0], wdata[31:8]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // busy is registered, so it is built from the post-edge FIFO count and FSM state.
    assign count_d   = fifo_count + CW'(push && !fifo_full) - CW'(pop);
    assign frame_end = (state_q == ST_STOP) && (baud_q == '0);
    assign busy_d    = pop || ((state_q != ST_IDLE) && !frame_end) || (count_d != '0);

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        status                            = '0;
        status[STAT_FULL]                 = fifo_full;
        status[STAT_EMPTY]                = fifo_empty;
        status[STAT_SHIFTING]             = (state_q != ST_IDLE);
        status[STAT_OVERFLOW]             = overflow_q;
`ifdef MMIO_UART_PARITY_EN
        status[STAT_PARITY]               = 1'b1;
`endif
        status[STAT_COUNT_LSB +: CW]      = fifo_count;
        rdata                             = sel_status ? status : 32'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (push && fifo_full) begin
            overflow_q <= 1'b1;
        end else if (we && sel_status && wdata[STAT_OVERFLOW]) begin
            overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef MMIO_UART_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            busy_q <= busy_d;
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        shift_q   <= fifo_dout;
                        bit_idx_q <= '0;
                        baud_q    <= BAUD_LOAD;
                        tx_q      <= 1'b0;
                        state_q   <= ST_START;
`ifdef MMIO_UART_PARITY_EN
                        parity_q  <= even_parity(fifo_dout);
`endif
                    end
                end
                ST_START: begin
                    if (baud_q == '0) begin
                        baud_q  <= BAUD_LOAD;
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_q == '0) begin
                        baud_q    <= BAUD_LOAD;
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= ST_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
`endif
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
`ifdef MMIO_UART_PARITY_EN
                ST_PARITY: begin
                    if (baud_q == '0) begin
                        baud_q  <= BAUD_LOAD;
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_q == '0) begin
                        tx_q    <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule
